// File: rtl/serial_match_ctrl.sv
// Run-time programmable serial pattern matcher with timeout and saturating match counter.
// Latency: result registered one cycle after the deciding bit, timeout or config error.
// Backpressure: result held in REPORT until done_vld&done_rdy; start/abort ignored meanwhile.
module serial_match_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int TO_W    = 16,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic [TO_W-1:0]    cfg_timeout,
    input  logic               start,
    input  logic               abort,
    input  logic               s_in,
    input  logic               s_vld,
    output logic               busy,
    output logic               done_vld,
    input  logic               done_rdy,
    output logic [1:0]         done_status,
    output logic [CNT_W-1:0]   match_cnt
);

    typedef enum logic [1:0] {IDLE, ARMED, REPORT} state_t;

    state_t             state;
    logic [MAX_LEN-1:0] pat_q;
    logic [MAX_LEN-1:0] sh;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   fill;
    logic [TO_W-1:0]    to_q;
    logic [TO_W-1:0]    timer;

    logic [MAX_LEN-1:0] sh_nxt;
    logic [MAX_LEN-1:0] len_mask;
    logic [LEN_W-1:0]   fill_nxt;
    logic               hit;
    logic               expire;
    logic               cfg_bad;

    always_comb begin
        sh_nxt   = s_vld ? {sh[MAX_LEN-2:0], s_in} : sh;
        fill_nxt = (s_vld && (fill < len_q)) ? fill + 1'b1 : fill;
        len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (LEN_W'(i) < len_q);
        end
        // The window only counts once len bits have arrived since start.
        hit     = (fill_nxt == len_q) && ((sh_nxt & len_mask) == (pat_q & len_mask));
        expire  = (to_q != '0) && (timer == to_q - 1'b1);
        cfg_bad = (cfg_len == '0) || (cfg_len > LEN_W'(MAX_LEN));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done_vld    <= 1'b0;
            done_status <= 2'b00;
            match_cnt   <= '0;
            pat_q       <= '0;
            len_q       <= '0;
            to_q        <= '0;
            sh          <= '0;
            fill        <= '0;
            timer       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pat_q <= cfg_pattern;
                        len_q <= cfg_len;
                        to_q  <= cfg_timeout;
                        sh    <= '0;
                        fill  <= '0;
                        timer <= '0;
                        busy  <= 1'b1;
                        if (cfg_bad) begin
                            state       <= REPORT;
                            done_vld    <= 1'b1;
                            done_status <= 2'b11;
                        end else begin
                            state <= ARMED;
                        end
                    end
                end
                ARMED: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        sh   <= sh_nxt;
                        fill <= fill_nxt;
                        if (hit) begin
                            state       <= REPORT;
                            done_vld    <= 1'b1;
                            done_status <= 2'b01;
                            if (match_cnt != '1) begin
                                match_cnt <= match_cnt + 1'b1;
                            end
                        end else if (expire) begin
                            state       <= REPORT;
                            done_vld    <= 1'b1;
                            done_status <= 2'b10;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                end
                REPORT: begin
                    if (done_rdy) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        done_vld    <= 1'b0;
                        done_status <= 2'b00;
                    end
                end
                default: begin
                    state       <= IDLE;
                    busy        <= 1'b0;
                    done_vld    <= 1'b0;
                    done_status <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_match_ctrl.sv
// Bench for serial_match_ctrl: directed scenarios plus random traffic against a bit-history model.
module tb_serial_match_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, abort, s_in, s_vld, done_rdy;
    logic [7:0]  cfg_pattern;
    logic [3:0]  cfg_len;
    logic [15:0] cfg_timeout;
    logic        busy, done_vld;
    logic [1:0]  done_status;
    logic [7:0]  match_cnt;

    always #5 clk = ~clk;

    serial_match_ctrl dut (
        .clk(clk), .rst(rst), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_timeout(cfg_timeout), .start(start), .abort(abort), .s_in(s_in),
        .s_vld(s_vld), .busy(busy), .done_vld(done_vld), .done_rdy(done_rdy),
        .done_status(done_status), .match_cnt(match_cnt)
    );

    int total = 0;
    int bad   = 0;

    // Reference: phase 0 idle, 1 running, 2 result pending; history of consumed bits.
    int         m_phase = 0;
    bit         hist[$];
    int         m_cycles, m_cnt, m_status, m_len, m_to;
    logic [7:0] m_pat;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit pattern_seen();
        if (hist.size() < m_len) return 1'b0;
        for (int i = 0; i < m_len; i++) begin
            if (hist[hist.size() - m_len + i] != m_pat[m_len - 1 - i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_step();
        if (rst) begin
            m_phase = 0; m_cnt = 0; m_status = 0; hist.delete();
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_pat = cfg_pattern; m_len = int'(cfg_len); m_to = int'(cfg_timeout);
                    hist.delete(); m_cycles = 0;
                    if (m_len < 1 || m_len > 8) begin m_phase = 2; m_status = 3; end
                    else m_phase = 1;
                end
                1: if (abort) m_phase = 0;
                   else begin
                       if (s_vld) hist.push_back(s_in);
                       m_cycles++;
                       if (pattern_seen()) begin
                           m_phase = 2; m_status = 1;
                           if (m_cnt < 255) m_cnt++;
                       end else if (m_to != 0 && m_cycles == m_to) begin
                           m_phase = 2; m_status = 2;
                       end
                   end
                default: if (done_rdy) begin m_phase = 0; m_status = 0; end
            endcase
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_eq("busy", busy, (m_phase != 0));
        check_eq("done_vld", done_vld, (m_phase == 2));
        check_eq("done_status", done_status, (m_phase == 2) ? m_status : 0);
        check_eq("match_cnt", match_cnt, m_cnt);
    endtask

    task automatic do_start(input logic [7:0] p, input logic [3:0] l, input logic [15:0] t);
        cfg_pattern = p; cfg_len = l; cfg_timeout = t; start = 1'b1;
        step();
        start = 1'b0;
        cfg_pattern = ~p; cfg_len = 4'd0; cfg_timeout = 16'd1;
    endtask

    task automatic bit_in(input logic b);
        s_vld = 1'b1; s_in = b;
        step();
        s_vld = 1'b0; s_in = 1'b0;
    endtask

    initial begin
        logic [6:0] gap_seq;
        logic [4:0] seq1;
        rst = 1'b1; start = 0; abort = 0; s_in = 0; s_vld = 0; done_rdy = 1'b1;
        cfg_pattern = '0; cfg_len = '0; cfg_timeout = '0;
        step(); step();
        rst = 1'b0;
        step();

        // Pattern 001, contiguous stream 1,1,0,0,1.
        seq1 = 5'b11001;
        do_start(8'h01, 4'd3, 16'd0);
        for (int i = 4; i >= 0; i--) bit_in(seq1[i]);
        check_eq("tp1_status", done_status, 2'b01);
        check_eq("tp1_cnt", match_cnt, 1);
        step();

        // Same pattern with two idle cycles between bits; no hit on the 010 prefix.
        gap_seq = 7'b0100001;
        do_start(8'h01, 4'd3, 16'd0);
        for (int i = 6; i >= 0; i--) begin
            bit_in(gap_seq[i]);
            if (i == 0) check_eq("tp2_status", done_status, 2'b01);
            else        check_eq("tp2_nohit", done_vld, 1'b0);
            step(); step();
        end

        // Timeout of 5 with constant ones; result held while done_rdy is low.
        done_rdy = 1'b0; s_in = 1'b1; s_vld = 1'b1;
        do_start(8'h01, 4'd3, 16'd5);
        s_in = 1'b1; s_vld = 1'b1;
        repeat (4) step();
        check_eq("tp3_early", done_vld, 1'b0);
        step();
        check_eq("tp3_status", done_status, 2'b10);
        repeat (3) step();
        check_eq("tp3_hold", done_status, 2'b10);
        s_vld = 1'b0; s_in = 1'b0; done_rdy = 1'b1;
        step();

        // Match on the same cycle the timeout would expire.
        do_start(8'h01, 4'd3, 16'd4);
        step();
        bit_in(1'b0); bit_in(1'b0); bit_in(1'b1);
        check_eq("tp4_status", done_status, 2'b01);
        step();

        // Illegal lengths.
        do_start(8'hFF, 4'd0, 16'd0);
        check_eq("tp5_len0", done_status, 2'b11);
        step();
        do_start(8'hFF, 4'd9, 16'd0);
        check_eq("tp5_len9", done_status, 2'b11);
        step();

        // Abort mid-run.
        do_start(8'h01, 4'd3, 16'd0);
        bit_in(1'b0);
        abort = 1'b1; s_vld = 1'b1; s_in = 1'b1;
        step();
        abort = 1'b0; s_vld = 1'b0; s_in = 1'b0;
        check_eq("tp6_abort_busy", busy, 1'b0);
        step();

        // Reset while a result is pending.
        done_rdy = 1'b0;
        do_start(8'h01, 4'd15, 16'd0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; done_rdy = 1'b1;
        check_eq("tp7_cnt", match_cnt, 0);
        step();

        // Counter saturation.
        repeat (256) begin
            do_start(8'h01, 4'd1, 16'd0);
            bit_in(1'b1);
            step();
        end
        check_eq("tp8_sat", match_cnt, 255);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            rst      = ($urandom % 250) == 0;
            start    = ($urandom % 4) == 0;
            abort    = ($urandom % 40) == 0;
            s_vld    = ($urandom % 3) != 0;
            s_in     = $urandom % 2;
            done_rdy = ($urandom % 3) != 0;
            cfg_pattern = 8'($urandom);
            cfg_len     = (($urandom % 8) == 0) ? 4'($urandom % 16) : 4'($urandom_range(1, 4));
            cfg_timeout = (($urandom % 3) == 0) ? 16'd0 : 16'($urandom_range(1, 30));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
